// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin conflict resolution,
// registered write port and saturating write/conflict statistics.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_t;

  grant_t            last_grant;
  logic              both_valid;
  logic              pick1;
  logic              xfer;
  logic              do_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Requester 1 wins when it is alone, or when both are valid and requester 0 went last.
  always_comb begin
    both_valid = req0_valid & req1_valid;
    pick1      = req1_valid & (~req0_valid | (last_grant == GRANT_REQ0));
    req0_ready = ~rst & ~hold & req0_valid & ~pick1;
    req1_ready = ~rst & ~hold & pick1;
    xfer       = req0_ready | req1_ready;
    sel_addr   = req1_ready ? req1_addr : req0_addr;
    sel_data   = req1_ready ? req1_data : req0_data;
    do_write   = xfer & (sel_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_addr      <= '0;
      rf_wdata     <= '0;
      wr_cnt       <= '0;
      conflict_cnt <= '0;
      last_grant   <= GRANT_REQ1;
    end else begin
      rf_we <= do_write;
      if (do_write) begin
        rf_addr  <= sel_addr;
        rf_wdata <= sel_data;
      end
      // Writes to the zero register still count as transfers for fairness.
      if (xfer)
        last_grant <= req1_ready ? GRANT_REQ1 : GRANT_REQ0;
      if (do_write && (wr_cnt != '1))
        wr_cnt <= wr_cnt + 1'b1;
      if (both_valid && !hold && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of write data.
REQ-002 Parameter: ADDR_W, default 5, width of register address; register 0 is the hardwired zero register.
REQ-003 Parameter: CNT_W, default 16, width of both statistics counters.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: hold  input  1  when high, no grant is issued.
REQ-007 Port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-008 Port: req0_addr  input  ADDR_W  requester 0 destination register.
REQ-009 Port: req0_data  input  DATA_W  requester 0 write data (signed two's complement, passed unmodified).
REQ-010 Port: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-011 Port: req1_valid / req1_addr / req1_data / req1_ready  same directions, widths and meanings for requester 1 (load unit).
REQ-012 Port: rf_we  output  1  register file write enable, registered.
REQ-013 Port: rf_addr  output  ADDR_W  register file write address, registered.
REQ-014 Port: rf_wdata  output  DATA_W  register file write data, registered.
REQ-015 Port: wr_cnt  output  CNT_W  number of rf_we pulses issued since reset.
REQ-016 Port: conflict_cnt  output  CNT_W  number of cycles with both requesters valid and hold low.

Function
REQ-017 Transfer on requester n SHALL occur in a cycle where reqn_valid and reqn_ready are both high.
REQ-018 reqn_ready SHALL be combinational: high only when rst low, hold low, reqn_valid high and requester n wins arbitration.
REQ-019 At most one reqn_ready SHALL be high in any cycle.
REQ-020 Only one requester valid: that requester SHALL win.
REQ-021 Both valid: the winner SHALL be the requester not granted most recently (1-bit last_grant pointer).
REQ-022 last_grant SHALL update only on a transfer; it SHALL hold during hold cycles and idle cycles.
REQ-023 A transfer in cycle N with address != 0: the next edge SHALL set rf_we=1, rf_addr=addr, rf_wdata=data. The write is visible in the register file after the edge of cycle N+1 (2-edge latency).
REQ-024 A transfer with address 0 SHALL be accepted (ready high, last_grant updated) but SHALL produce rf_we=0 in cycle N+1 and SHALL NOT increment wr_cnt.
REQ-025 Cycle with no transfer: the next edge SHALL set rf_we=0; rf_addr and rf_wdata SHALL hold their previous values.
REQ-026 Back-to-back transfers SHALL be supported every cycle; throughput one write per cycle.
REQ-027 wr_cnt SHALL increment by 1 on each edge that sets rf_we=1; it saturates at all-ones and does not wrap.
REQ-028 conflict_cnt SHALL increment by 1 on each edge following a cycle with req0_valid, req1_valid both high and hold low; it saturates at all-ones.
REQ-029 Raising hold SHALL not cancel a write already registered on rf_we; that write completes in the following cycle.
REQ-030 A requester SHALL keep valid, addr and data stable until its transfer; the arbiter SHALL accept whatever is presented in the transfer cycle.

Reset
REQ-031 With rst high on an edge: rf_we=0, rf_addr=0, rf_wdata=0, wr_cnt=0, conflict_cnt=0, last_grant=1 (requester 0 wins the first conflict).
REQ-032 While rst is high, req0_ready and req1_ready SHALL be 0; no transfer occurs.
REQ-033 rst asserted while rf_we=1 SHALL clear rf_we at that edge; the pending write is dropped.

Verification
REQ-034 After reset, req0 only, addr=3, data=0x0000_00AA -> req0_ready=1 that cycle; next cycle rf_we=1, rf_addr=3, rf_wdata=0x0000_00AA; wr_cnt=1.
REQ-035 Both valid for 4 cycles (req0 addr 1/2, req1 addr 5/6, new data each transfer) -> grants 0,1,0,1; rf_addr 1,5,2,6; conflict_cnt=4 (req0 deasserts after 2nd grant).
REQ-036 req1 valid, addr=0, data=0xDEAD_BEEF -> req1_ready=1; next cycle rf_we=0; wr_cnt unchanged.
REQ-037 hold=1 with both valid for 3 cycles -> both ready 0, rf_we=0, conflict_cnt unchanged; hold drops -> requester opposite last_grant wins.
REQ-038 Transfer in cycle N, rst=1 in cycle N+1 -> rf_we=0 after that edge, wr_cnt=0, both ready 0 during reset.
REQ-039 CNT_W=4, 17 consecutive nonzero-address writes -> wr_cnt stops at 0xF.
